// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a frame-latched test-pattern engine.
// Two free-running raster counters feed a fully registered output stage.
// The stage advances only on pix_en, so every output describes the counter
// position sampled at the previous enabled edge.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 1,
  parameter int CHECK_LOG2 = 5,
  parameter int FRAME_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_en,
  input  logic [2:0]             sw,
  input  logic [1:0]             mode,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   video_on,
  output logic [9:0]             pixel_x,
  output logic [9:0]             pixel_y,
  output logic [3*COLOR_W-1:0]   rgb,
  output logic                   sof,
  output logic [FRAME_W-1:0]     frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // Both counters are 10 bits wide and the checkerboard taps one of their bits.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CHECK_LOG2 > 9) begin : g_bad_params
    $error("vga_timing_gen: raster totals must not exceed 1024 and CHECK_LOG2 must be below 10");
  end

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'b00,
    MODE_BARS   = 2'b01,
    MODE_CHECK  = 2'b10,
    MODE_BORDER = 2'b11
  } mode_e;

  // First column of colour bar k: smallest h with h*8 >= k*H_ACTIVE.
  function automatic int bar_edge(input int k);
    return (k * H_ACTIVE + 7) / 8;
  endfunction

  logic [9:0]             h_cnt_q, h_cnt_d;
  logic [9:0]             v_cnt_q, v_cnt_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  mode_e                  mode_q, mode_d;
  logic [2:0]             color_q, color_d;

  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   video_on_q, video_on_d;
  logic [9:0]             pixel_x_q, pixel_x_d;
  logic [9:0]             pixel_y_q, pixel_y_d;
  logic [3*COLOR_W-1:0]   rgb_q, rgb_d;
  logic                   sof_q, sof_d;

  int                     h_int, v_int;
  logic                   at_origin, h_last, v_last, in_active, on_border;
  mode_e                  eff_mode;
  logic [2:0]             eff_color;
  logic [2:0]             bar_idx;
  logic [2:0]             pat_color;

  // Decode the current raster position.
  always_comb begin
    h_int     = int'(h_cnt_q);
    v_int     = int'(v_cnt_q);
    at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    h_last    = (h_int == H_TOTAL - 1);
    v_last    = (v_int == V_TOTAL - 1);
    in_active = (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
    on_border = (h_int == 0) || (h_int == H_ACTIVE - 1) ||
                (v_int == 0) || (v_int == V_ACTIVE - 1);
  end

  // Raster counters and completed-frame counter; all advance only on pix_en.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    frame_d = frame_q;
    if (pix_en) begin
      if (h_last) begin
        h_cnt_d = 10'd0;
        if (v_last) begin
          v_cnt_d = 10'd0;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Latch pattern mode and colour at the top-left pixel; the pixel that
  // performs the latch already uses the new values.
  always_comb begin
    mode_d    = mode_q;
    color_d   = color_q;
    eff_mode  = mode_q;
    eff_color = color_q;
    if (at_origin) begin
      eff_mode  = mode_e'(mode);
      eff_color = sw;
      if (pix_en) begin
        mode_d  = mode_e'(mode);
        color_d = sw;
      end
    end
  end

  // Pattern engine: bar index by comparison against constant bar edges.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_int >= bar_edge(k)) bar_idx = bar_idx + 3'd1;
    end
    pat_color = eff_color;
    case (eff_mode)
      MODE_SOLID:  pat_color = eff_color;
      MODE_BARS:   pat_color = ~bar_idx;
      MODE_CHECK:  pat_color = (h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2]) ? ~eff_color : eff_color;
      MODE_BORDER: pat_color = on_border ? 3'b111 : eff_color;
    endcase
  end

  // Output stage next state: load on pix_en, otherwise hold.
  always_comb begin
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    pixel_x_d  = pixel_x_q;
    pixel_y_d  = pixel_y_q;
    rgb_d      = rgb_q;
    sof_d      = sof_q;
    if (pix_en) begin
      hsync_d    = (h_int >= HS_START && h_int <= HS_END) ? HS_POL : ~HS_POL;
      vsync_d    = (v_int >= VS_START && v_int <= VS_END) ? VS_POL : ~VS_POL;
      video_on_d = in_active;
      pixel_x_d  = h_cnt_q;
      pixel_y_d  = v_cnt_q;
      rgb_d      = in_active ? {{COLOR_W{pat_color[2]}}, {COLOR_W{pat_color[1]}},
                                {COLOR_W{pat_color[0]}}} : '0;
      sof_d      = at_origin;
    end
  end

  // State register for counters, frame latch and output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q    <= 10'd0;
      v_cnt_q    <= 10'd0;
      frame_q    <= '0;
      mode_q     <= MODE_SOLID;
      color_q    <= 3'b000;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      video_on_q <= 1'b0;
      pixel_x_q  <= 10'd0;
      pixel_y_q  <= 10'd0;
      rgb_q      <= '0;
      sof_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      frame_q    <= frame_d;
      mode_q     <= mode_d;
      color_q    <= color_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      pixel_x_q  <= pixel_x_d;
      pixel_y_q  <= pixel_y_d;
      rgb_q      <= rgb_d;
      sof_q      <= sof_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign pixel_x   = pixel_x_q;
  assign pixel_y   = pixel_y_q;
  assign rgb       = rgb_q;
  assign sof       = sof_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full defaults, default H with a
// short frame, and a tiny active-high 4-bit-colour raster) against a
// behavioural raster model feeding an expected-output queue.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic [11:0] rgb;
    logic       sof;
    logic [7:0] frame;
  } out_t;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hp, vp;
    int cw;
  } cfg_t;

  typedef struct {
    int       h, v, frame;
    bit [1:0] lmode;
    bit [2:0] lcol;
    out_t     out;
  } mdl_t;

  logic clk;
  logic rst_d, rst_m, rst_s;
  logic pix_en;
  logic [2:0] sw;
  logic [1:0] mode;

  logic hs_d, vs_d, von_d, sof_d;
  logic [9:0] x_d, y_d;
  logic [2:0] rgb_d;
  logic [7:0] fc_d;

  logic hs_m, vs_m, von_m, sof_m;
  logic [9:0] x_m, y_m;
  logic [2:0] rgb_m;
  logic [7:0] fc_m;

  logic hs_s, vs_s, von_s, sof_s;
  logic [9:0] x_s, y_s;
  logic [11:0] rgb_s;
  logic [7:0] fc_s;

  cfg_t cfg [3];
  mdl_t mdl [3];
  out_t exp_q [$];
  out_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  vga_timing_gen dut_d (
    .clk(clk), .reset(rst_d), .pix_en(pix_en), .sw(sw), .mode(mode),
    .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .pixel_x(x_d), .pixel_y(y_d),
    .rgb(rgb_d), .sof(sof_d), .frame_cnt(fc_d)
  );

  vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_m (
    .clk(clk), .reset(rst_m), .pix_en(pix_en), .sw(sw), .mode(mode),
    .hsync(hs_m), .vsync(vs_m), .video_on(von_m), .pixel_x(x_m), .pixel_y(y_m),
    .rgb(rgb_m), .sof(sof_m), .frame_cnt(fc_m)
  );

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                   .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4)) dut_s (
    .clk(clk), .reset(rst_s), .pix_en(pix_en), .sw(sw), .mode(mode),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .pixel_x(x_s), .pixel_y(y_s),
    .rgb(rgb_s), .sof(sof_s), .frame_cnt(fc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t get_obs(input int k);
    out_t o;
    case (k)
      0:       o = {hs_d, vs_d, von_d, x_d, y_d, 9'b0, rgb_d, sof_d, fc_d};
      1:       o = {hs_m, vs_m, von_m, x_m, y_m, 9'b0, rgb_m, sof_m, fc_m};
      default: o = {hs_s, vs_s, von_s, x_s, y_s, rgb_s, sof_s, fc_s};
    endcase
    return o;
  endfunction

  function automatic logic [2:0] pattern(input cfg_t c, input int h, input int v,
                                         input bit [1:0] md, input bit [2:0] col);
    int b;
    case (md)
      2'd0: return col;
      2'd1: begin
        b = (h * 8) / c.ha;
        return 3'(7 - b);
      end
      2'd2: return ((((h / 32) % 2) != ((v / 32) % 2))) ? ~col : col;
      default: return (h == 0 || h == c.ha - 1 || v == 0 || v == c.va - 1) ? 3'b111 : col;
    endcase
  endfunction

  function automatic logic [11:0] expand(input logic [2:0] col, input int cw);
    logic [11:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int j = 0; j < cw; j++) r[ch * cw + j] = col[ch];
    return r;
  endfunction

  function automatic void model_reset(input int k);
    mdl[k].h      = 0;
    mdl[k].v      = 0;
    mdl[k].frame  = 0;
    mdl[k].lmode  = 2'b00;
    mdl[k].lcol   = 3'b000;
    mdl[k].out    = '0;
    mdl[k].out.hs = ~cfg[k].hp;
    mdl[k].out.vs = ~cfg[k].vp;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge(input int k);
    mdl_t m;
    cfg_t c;
    bit org;
    int htot, vtot;
    logic [2:0] col;
    m = mdl[k];
    c = cfg[k];
    if (pix_en) begin
      htot = c.ha + c.hfp + c.hsw + c.hbp;
      vtot = c.va + c.vfp + c.vsw + c.vbp;
      org  = (m.h == 0 && m.v == 0);
      if (org) begin
        m.lmode = mode;
        m.lcol  = sw;
      end
      m.out.x   = 10'(m.h);
      m.out.y   = 10'(m.v);
      m.out.hs  = (m.h >= c.ha + c.hfp && m.h < c.ha + c.hfp + c.hsw) ? c.hp : ~c.hp;
      m.out.vs  = (m.v >= c.va + c.vfp && m.v < c.va + c.vfp + c.vsw) ? c.vp : ~c.vp;
      m.out.von = (m.h < c.ha) && (m.v < c.va);
      col       = m.out.von ? pattern(c, m.h, m.v, m.lmode, m.lcol) : 3'b000;
      m.out.rgb = expand(col, c.cw);
      m.out.sof = org;
      if (m.h == htot - 1 && m.v == vtot - 1) m.frame = (m.frame + 1) % 256;
      m.out.frame = 8'(m.frame);
      m.h = m.h + 1;
      if (m.h == htot) begin
        m.h = 0;
        m.v = (m.v + 1) % vtot;
      end
    end
    mdl[k] = m;
  endfunction

  // One clock: push the expectation, let the edge happen, pop and compare.
  task automatic step(input int k);
    out_t e;
    model_edge(k);
    exp_q.push_back(mdl[k].out);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    cur = get_obs(k);
    e   = exp_q.pop_front();
    checks++;
    if (cur !== e) begin
      errors++;
      $display("FAIL scoreboard dut%0d cycle %0d: got hs=%b vs=%b von=%b x=%0d y=%0d rgb=%h sof=%b fc=%0d, want hs=%b vs=%b von=%b x=%0d y=%0d rgb=%h sof=%b fc=%0d",
               k, cyc, cur.hs, cur.vs, cur.von, cur.x, cur.y, cur.rgb, cur.sof, cur.frame,
               e.hs, e.vs, e.von, e.x, e.y, e.rgb, e.sof, e.frame);
    end
  endtask

  task automatic reset_dut(input int k);
    case (k)
      0:       rst_d = 1'b0;
      1:       rst_m = 1'b0;
      default: rst_s = 1'b0;
    endcase
    repeat (2) @(negedge clk);
    model_reset(k);
    case (k)
      0:       rst_d = 1'b1;
      1:       rst_m = 1'b1;
      default: rst_s = 1'b1;
    endcase
  endtask

  task automatic test_reset();
    out_t o;
    for (int k = 0; k < 3; k++) begin
      o = get_obs(k);
      checks++;
      if (o !== mdl[k].out) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h want %h", k, o, mdl[k].out);
      end
    end
    checks++;
    if (hs_d !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hs_d); end
    checks++;
    if (vs_d !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vs_d); end
    checks++;
    if (rgb_d !== 3'b000) begin errors++; $display("FAIL reset_rgb got %b want 000", rgb_d); end
    rst_d = 1'b1;
    step(0);
    checks++;
    if ({cur.x, cur.y} !== 20'd0) begin
      errors++; $display("FAIL first_pixel got x=%0d y=%0d want 0,0", cur.x, cur.y);
    end
    checks++;
    if ({cur.sof, cur.von} !== 2'b11) begin
      errors++; $display("FAIL first_sof_von got sof=%b von=%b want 1 1", cur.sof, cur.von);
    end
    checks++;
    if (cur.rgb !== 12'h004) begin
      errors++; $display("FAIL first_rgb got %h want 004", cur.rgb);
    end
  endtask

  task automatic test_line();
    int hs_lo = 0, hs_first = -1, hs_last = -1, von_cnt = 0, t1 = -1, t2 = -1;
    for (int i = 0; i < 1600; i++) begin
      step(0);
      if (cur.y == 10'd1) begin
        if (!cur.hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(cur.x);
          hs_last = int'(cur.x);
        end
        if (cur.von) von_cnt++;
        if (cur.x == 10'd0) t1 = i;
      end
      if (cur.y == 10'd2 && cur.x == 10'd0) t2 = i;
    end
    checks++;
    if (hs_lo !== 96) begin errors++; $display("FAIL hsync_width got %0d want 96", hs_lo); end
    checks++;
    if (hs_first !== 656 || hs_last !== 751) begin
      errors++; $display("FAIL hsync_span got %0d..%0d want 656..751", hs_first, hs_last);
    end
    checks++;
    if (von_cnt !== 640) begin errors++; $display("FAIL video_on_width got %0d want 640", von_cnt); end
    checks++;
    if (t2 - t1 !== 800) begin errors++; $display("FAIL line_period got %0d want 800", t2 - t1); end
  endtask

  task automatic test_pix_en();
    int starts [3] = '{-1, -1, -1};
    int ns = 0, sof_en = 0, sof_clk = 0, prev_x = -1;
    mode = 2'b10;
    sw   = 3'b001;
    reset_dut(0);
    for (int i = 0; i < 3300; i++) begin
      pix_en = (i % 2 == 0);
      step(0);
      if (cur.sof) begin
        sof_clk++;
        if (pix_en) sof_en++;
      end
      if (cur.x == 10'd0 && prev_x != 0 && ns < 3) begin
        starts[ns] = i;
        ns++;
      end
      prev_x = int'(cur.x);
    end
    pix_en = 1'b1;
    checks++;
    if (starts[1] - starts[0] !== 1600 || starts[2] - starts[1] !== 1600) begin
      errors++; $display("FAIL gated_line_period got %0d,%0d want 1600", starts[1] - starts[0], starts[2] - starts[1]);
    end
    checks++;
    if (sof_en !== 1) begin errors++; $display("FAIL gated_sof_enabled got %0d want 1", sof_en); end
    checks++;
    if (sof_clk !== 2) begin errors++; $display("FAIL gated_sof_clocks got %0d want 2", sof_clk); end
  endtask

  task automatic test_frames_mode();
    int sof_idx [3] = '{-1, -1, -1};
    logic [7:0] sof_fc [3];
    int ns = 0, vs_cnt = 0, vs_first = -1, vs_y_lo = -1, vs_y_hi = -1;
    int bx [6] = '{0, 79, 80, 159, 560, 639};
    logic [11:0] bc [6] = '{12'h007, 12'h007, 12'h006, 12'h006, 12'h000, 12'h000};
    sof_fc = '{8'hxx, 8'hxx, 8'hxx};
    mode = 2'b00;
    sw   = 3'b010;
    reset_dut(1);
    for (int i = 0; i <= 16000; i++) begin
      step(1);
      if (i == 1700) mode = 2'b01;
      if (cur.sof && ns < 3) begin
        sof_idx[ns] = i;
        sof_fc[ns]  = cur.frame;
        ns++;
      end
      if (i < 8000 && !cur.vs) begin
        vs_cnt++;
        if (vs_first < 0) begin vs_first = i; vs_y_lo = int'(cur.y); end
        vs_y_hi = int'(cur.y);
      end
      if (i == 2700) begin
        checks++;
        if (cur.rgb !== 12'h002) begin
          errors++; $display("FAIL no_tearing got %h want 002", cur.rgb);
        end
      end
      for (int j = 0; j < 6; j++) begin
        if (i == 8000 + bx[j]) begin
          checks++;
          if (cur.rgb !== bc[j]) begin
            errors++; $display("FAIL bars_x%0d got %h want %h", bx[j], cur.rgb, bc[j]);
          end
        end
      end
    end
    mode = 2'b00;
    checks++;
    if (sof_idx[1] - sof_idx[0] !== 8000 || sof_idx[2] - sof_idx[1] !== 8000) begin
      errors++; $display("FAIL frame_period got %0d,%0d want 8000", sof_idx[1] - sof_idx[0], sof_idx[2] - sof_idx[1]);
    end
    checks++;
    if ({sof_fc[0], sof_fc[1], sof_fc[2]} !== {8'd0, 8'd1, 8'd2}) begin
      errors++; $display("FAIL frame_cnt_seq got %0d,%0d,%0d want 0,1,2", sof_fc[0], sof_fc[1], sof_fc[2]);
    end
    checks++;
    if (vs_cnt !== 1600 || vs_first !== 4800) begin
      errors++; $display("FAIL vsync_window got %0d clocks from %0d want 1600 from 4800", vs_cnt, vs_first);
    end
    checks++;
    if (vs_y_lo !== 6 || vs_y_hi !== 7) begin
      errors++; $display("FAIL vsync_rows got %0d..%0d want 6..7", vs_y_lo, vs_y_hi);
    end
  endtask

  task automatic test_small_reset();
    int hs_cnt = 0, hs_first = -1;
    out_t o;
    mode = 2'b00;
    sw   = 3'b101;
    reset_dut(2);
    for (int i = 0; i <= 53; i++) begin
      step(2);
      if (i == 0) begin
        checks++;
        if (cur.rgb !== 12'hF0F) begin errors++; $display("FAIL wide_rgb got %h want f0f", cur.rgb); end
      end
      if (cur.y == 10'd0 && cur.hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(cur.x);
      end
    end
    checks++;
    if (hs_cnt !== 2 || hs_first !== 10) begin
      errors++; $display("FAIL hsync_active_high got %0d clocks from x=%0d want 2 from x=10", hs_cnt, hs_first);
    end
    checks++;
    if ({cur.x, cur.y} !== {10'd5, 10'd3}) begin
      errors++; $display("FAIL pre_reset_pixel got %0d,%0d want 5,3", cur.x, cur.y);
    end
    #2 rst_s = 1'b0;
    #1;
    model_reset(2);
    o = get_obs(2);
    checks++;
    if (o !== mdl[2].out) begin
      errors++; $display("FAIL midframe_reset got %h want %h", o, mdl[2].out);
    end
    @(negedge clk);
    rst_s = 1'b1;
    step(2);
    checks++;
    if ({cur.x, cur.y, cur.sof} !== {10'd0, 10'd0, 1'b1}) begin
      errors++; $display("FAIL restart got x=%0d y=%0d sof=%b want 0 0 1", cur.x, cur.y, cur.sof);
    end
  endtask

  task automatic test_frame_wrap();
    mode = 2'b11;
    sw   = 3'b011;
    for (int i = 1; i <= 256 * 128; i++) begin
      step(2);
      if (i == 255 * 128) begin
        checks++;
        if ({cur.sof, cur.frame} !== {1'b1, 8'd255}) begin
          errors++; $display("FAIL frame_cnt_255 got sof=%b fc=%0d want 1 255", cur.sof, cur.frame);
        end
      end
      if (i == 256 * 128) begin
        checks++;
        if ({cur.sof, cur.frame} !== {1'b1, 8'd0}) begin
          errors++; $display("FAIL frame_cnt_wrap got sof=%b fc=%0d want 1 0", cur.sof, cur.frame);
        end
      end
    end
  endtask

  initial begin
    rst_d  = 1'b0;
    rst_m  = 1'b0;
    rst_s  = 1'b0;
    pix_en = 1'b1;
    sw     = 3'b100;
    mode   = 2'b00;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1};
    cfg[1] = '{640, 16, 96, 48, 4, 2, 2, 2, 1'b0, 1'b0, 1};
    cfg[2] = '{8, 2, 2, 4, 4, 1, 1, 2, 1'b1, 1'b1, 4};
    for (int k = 0; k < 3; k++) model_reset(k);
    repeat (3) @(negedge clk);
    test_reset();
    test_line();
    test_pix_en();
    test_frames_mode();
    test_small_reset();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with built-in test-pattern engine. Next generation of the team's fixed 640x480 sync generator.
- Timing is configurable per axis. Sync polarity is selectable. A pixel-clock enable allows running from a faster system clock.
- Adds a start-of-frame strobe, a frame counter and four frame-latched pattern modes.
- Sits between the clock/reset block and the DAC/pin driver. Also used standalone for board bring-up.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- COLOR_W, 1, bits per colour channel
- CHECK_LOG2, 5, log2 of checkerboard square size (pixels)
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel advance enable; tie to 1 for a clk equal to pixel clock
- sw  in  3  base colour {R,G,B}
- mode  in  2  pattern select: 00 solid, 01 colour bars, 10 checkerboard, 11 border box
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_on  out  1  high inside the active area
- pixel_x  out  10  column of the current output pixel
- pixel_y  out  10  row of the current output pixel
- rgb  out  3*COLOR_W  {R,G,B}; each channel is all-ones or all-zeros
- sof  out  1  high while the output pixel is (0,0)
- frame_cnt  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

Behaviour:
- Totals: H_TOTAL = sum of H params; V_TOTAL = sum of V params. Both must be ≤ 1024; checked by elaboration-time assertion.
- Internal counters h_cnt and v_cnt change only on clk edges with pix_en=1.
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, then wraps to 0.
- Output stage is fully registered and loads only when pix_en=1. With pix_en=0, every output and counter holds its value.
- Latency: all outputs describe the counter position sampled at the previous enabled edge. All outputs are mutually aligned.
- hsync is active when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync is active when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- video_on = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- When video_on=0, rgb is all zeros.
- Pattern mode and sw are latched into a frame register only when h_cnt=0, v_cnt=0 and pix_en=1. Mid-frame changes take effect at the next frame, so there is no tearing.
- Pattern definitions, where c = latched sw:
  - 00 solid: rgb = c.
  - 01 colour bars: bar index b = (h_cnt*8)/H_ACTIVE, 0..7. Colour = 7-b, giving white first and black last. Implemented as compare against precomputed constant bar edges; no runtime divider.
  - 10 checkerboard: colour is c if h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2] = 0, otherwise ~c.
  - 11 border box: white on h_cnt=0, h_cnt=H_ACTIVE-1, v_cnt=0 or v_cnt=V_ACTIVE-1; c elsewhere.
- 3-bit colour expansion: each colour bit is replicated COLOR_W times.
- sof is a one-cycle pulse, qualified by pix_en, in the output stage when the output pixel is (0,0).
- frame_cnt increments on the enabled edge where both counters wrap, i.e. h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. It wraps from 2^FRAME_W-1 to 0.
- Reset values:
  - h_cnt=0, v_cnt=0.
  - pixel_x=0, pixel_y=0.
  - hsync=~HS_POL, vsync=~VS_POL (inactive).
  - video_on=0, rgb=0, sof=0, frame_cnt=0.
  - Latched mode=00, latched colour=000.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). Counting restarts at (0,0) on the first enabled edge after release.
- First enabled edge after reset: the output stage loads pixel (0,0), so sof=1 and video_on=1. The mode and colour latched on that edge apply to that pixel.

Test Plan:
- Release reset with pix_en=1, sw=3'b100, mode=00:
  - one edge later: pixel_x=0, pixel_y=0, sof=1, video_on=1, rgb=red.
  - during reset: hsync=1, vsync=1, rgb=0.
- Defaults, one line: hsync low for exactly 96 clocks on output pixel_x 656..751; video_on high for 640 clocks; line period 800 clocks.
- Defaults, full frames: vsync low on pixel_y 490..491; frame period 420000 clocks; frame_cnt goes 0→1→2; frame_cnt wraps 255→0 after 256 frames.
- pix_en toggled 1/0 every clock: all outputs hold on pix_en=0 cycles; line period becomes 1600 clocks; sof stays high for exactly one enabled cycle.
- Switch mode 00→01 at pixel (100,200): the rest of the frame stays solid. Next frame shows bars: x=0..79 white, x=80..159 yellow, …, x=560..639 black.
- Override parameters to H 8/2/2/4, V 4/1/1/2, HS_POL=VS_POL=1, COLOR_W=4, then assert reset at pixel (5,3): hsync is active-high on x=10..11; rgb is 12 bits; reset mid-frame forces all outputs to reset values; restart at (0,0).
